// File: rtl/mem_responder.sv
// Word memory answering req/ack accesses after a programmable number of
// wait states; misaligned or out-of-range accesses fault without writing.
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [31:0] Address,
  input  logic [31:0] Datain,
  output logic [31:0] Dataout,
  output logic        Ack,
  output logic        Busy,
  output logic        Fault,
  output logic [1:0]  FaultCode
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [3:0]    cnt;
  logic          enter_resp;

  logic          wr_q;
  logic [31:0]   data_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    code_q;

  logic [1:0]    code_in;
  logic [AW-1:0] idx_in;

  logic          acc_wr;
  logic [31:0]   acc_data;
  logic [AW-1:0] acc_idx;
  logic [1:0]    acc_code;

  logic [31:0]   mem [DEPTH];

  assign code_in[0] = |Address[1:0];
  assign code_in[1] = Address[31:2] >= 30'(DEPTH);
  assign idx_in     = Address[AW+1:2];

  assign Ack  = (state == S_RESP);
  assign Busy = (state != S_IDLE);

  always_comb begin
    state_n    = state;
    enter_resp = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (Req) begin
          if (LATENCY == 0) begin
            state_n    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_n    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // With zero wait states the access resolves on its own capture edge
  always_comb begin
    acc_wr   = wr_q;
    acc_data = data_q;
    acc_idx  = idx_q;
    acc_code = code_q;
    if (state == S_IDLE) begin
      acc_wr   = Wr;
      acc_data = Datain;
      acc_idx  = idx_in;
      acc_code = code_in;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && Req) begin
        cnt <= 4'(LATENCY);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && state == S_IDLE && Req) begin
      wr_q   <= Wr;
      data_q <= Datain;
      idx_q  <= idx_in;
      code_q <= code_in;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Dataout   <= 32'd0;
      Fault     <= 1'b0;
      FaultCode <= 2'b00;
    end else if (enter_resp) begin
      if (|acc_code) begin
        Dataout   <= 32'd0;
        Fault     <= 1'b1;
        FaultCode <= acc_code;
      end else begin
        Fault     <= 1'b0;
        FaultCode <= 2'b00;
        if (!acc_wr) begin
          Dataout <= mem[acc_idx];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && enter_resp && !(|acc_code) && acc_wr) begin
      mem[acc_idx] <= acc_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized accesses
// against a word-array model, on a 2-wait-state and a 0-wait-state instance.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2, req2, wr2, ack2, busy2, f2;
  logic [31:0] a2, d2, q2;
  logic [1:0]  fc2;
  logic        rst0, req0, wr0, ack0, busy0, f0;
  logic [31:0] a0, d0, q0;
  logic [1:0]  fc0;

  int tests = 0;
  int fails = 0;

  logic [31:0] mdl2 [256];
  logic [31:0] mdl0 [256];
  logic [31:0] last2, last0;

  mem_responder #(.DEPTH(256), .LATENCY(2)) dut2 (
    .Clk(clk), .Reset(rst2), .Req(req2), .Wr(wr2),
    .Address(a2), .Datain(d2), .Dataout(q2), .Ack(ack2),
    .Busy(busy2), .Fault(f2), .FaultCode(fc2)
  );

  mem_responder #(.DEPTH(256), .LATENCY(0)) dut0 (
    .Clk(clk), .Reset(rst0), .Req(req0), .Wr(wr0),
    .Address(a0), .Datain(d0), .Dataout(q0), .Ack(ack0),
    .Busy(busy0), .Fault(f0), .FaultCode(fc0)
  );

  function automatic logic [1:0] exp_code(input logic [31:0] a);
    return {a[31:2] >= 30'd256, a[1:0] != 2'b00};
  endfunction

  // Reference model: word array plus the last value shown on Dataout
  task automatic model_step(input int which, input logic w,
                            input logic [31:0] addr, input logic [31:0] dat,
                            output logic [31:0] eq, output logic ef,
                            output logic [1:0] ec);
    logic [1:0] code;
    logic [31:0] last;
    code = exp_code(addr);
    last = (which == 0) ? last0 : last2;
    if (code != 2'b00) begin
      eq = 32'd0; ef = 1'b1; ec = code;
    end else begin
      ef = 1'b0; ec = 2'b00;
      if (w) begin
        if (which == 0) mdl0[addr[9:2]] = dat;
        else mdl2[addr[9:2]] = dat;
        eq = last;
      end else begin
        eq = (which == 0) ? mdl0[addr[9:2]] : mdl2[addr[9:2]];
      end
    end
    if (which == 0) last0 = eq;
    else last2 = eq;
  endtask

  // Starts at a negedge; returns at the negedge after the response
  task automatic access(input int which, input logic w,
                        input logic [31:0] addr, input logic [31:0] dat,
                        output logic [31:0] q, output logic f,
                        output logic [1:0] fc, output int ack_c,
                        output int ack_n, output int busy_n);
    logic a, b, ff;
    logic [31:0] qq;
    logic [1:0] cc;
    ack_c = 0; ack_n = 0; busy_n = 0;
    q = '0; f = 1'b0; fc = 2'b00;
    if (which == 0) begin
      req0 = 1'b1; wr0 = w; a0 = addr; d0 = dat;
    end else begin
      req2 = 1'b1; wr2 = w; a2 = addr; d2 = dat;
    end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (which == 0) begin
        a = ack0; b = busy0; qq = q0; ff = f0; cc = fc0;
      end else begin
        a = ack2; b = busy2; qq = q2; ff = f2; cc = fc2;
      end
      if (b) busy_n++;
      if (a) begin
        ack_n++;
        if (ack_c == 0) begin
          ack_c = c; q = qq; f = ff; fc = cc;
          if (which == 0) req0 = 1'b0;
          else req2 = 1'b0;
        end
      end
      if (ack_c != 0 && !a && !b) break;
    end
    req0 = 1'b0;
    req2 = 1'b0;
  endtask

  task automatic test_reset();
    rst2 = 1'b1; rst0 = 1'b1;
    req2 = 1'b0; req0 = 1'b0;
    wr2 = 1'b0; wr0 = 1'b0;
    a2 = '0; a0 = '0; d2 = '0; d0 = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({q2, ack2, busy2, f2, fc2} !== 37'd0) begin
      fails++;
      $display("FAIL reset_l2: got q=%h ack=%b busy=%b f=%b fc=%b want all 0",
               q2, ack2, busy2, f2, fc2);
    end
    tests++;
    if ({q0, ack0, busy0, f0, fc0} !== 37'd0) begin
      fails++;
      $display("FAIL reset_l0: got q=%h ack=%b busy=%b f=%b fc=%b want all 0",
               q0, ack0, busy0, f0, fc0);
    end
    rst2 = 1'b0; rst0 = 1'b0;
    last2 = '0; last0 = '0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [31:0] q, eq;
    logic f, ef;
    logic [1:0] fc, ec;
    int ac, an, bn;
    model_step(2, 1'b1, 32'h10, 32'hDEADBEEF, eq, ef, ec);
    access(2, 1'b1, 32'h10, 32'hDEADBEEF, q, f, fc, ac, an, bn);
    tests++;
    if (ac !== 3 || an !== 1) begin
      fails++;
      $display("FAIL wr_ack_timing: got cycle=%0d n=%0d want cycle=3 n=1", ac, an);
    end
    tests++;
    if (bn !== 3) begin
      fails++;
      $display("FAIL wr_busy_len: got %0d want 3", bn);
    end
    tests++;
    if (f !== 1'b0 || fc !== 2'b00) begin
      fails++;
      $display("FAIL wr_fault: got f=%b fc=%b want 0 00", f, fc);
    end
    model_step(2, 1'b0, 32'h10, 32'h0, eq, ef, ec);
    access(2, 1'b0, 32'h10, 32'h0, q, f, fc, ac, an, bn);
    tests++;
    if (q !== 32'hDEADBEEF || f !== 1'b0) begin
      fails++;
      $display("FAIL rd_data: got %h f=%b want deadbeef f=0", q, f);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] q, eq;
    logic f, ef;
    logic [1:0] fc, ec;
    int ac, an, bn;
    model_step(2, 1'b1, 32'h13, 32'h12345678, eq, ef, ec);
    access(2, 1'b1, 32'h13, 32'h12345678, q, f, fc, ac, an, bn);
    tests++;
    if (f !== 1'b1 || fc !== 2'b01 || q !== 32'd0 || ac !== 3) begin
      fails++;
      $display("FAIL misaligned_wr: got f=%b fc=%b q=%h cyc=%0d want 1 01 0 3",
               f, fc, q, ac);
    end
    model_step(2, 1'b0, 32'h10, 32'h0, eq, ef, ec);
    access(2, 1'b0, 32'h10, 32'h0, q, f, fc, ac, an, bn);
    tests++;
    if (q !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL misaligned_no_write: got %h want deadbeef", q);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] q, eq;
    logic f, ef;
    logic [1:0] fc, ec;
    int ac, an, bn;
    model_step(2, 1'b0, 32'h400, 32'h0, eq, ef, ec);
    access(2, 1'b0, 32'h400, 32'h0, q, f, fc, ac, an, bn);
    tests++;
    if (f !== 1'b1 || fc !== 2'b10 || q !== 32'd0) begin
      fails++;
      $display("FAIL oor_rd: got f=%b fc=%b q=%h want 1 10 0", f, fc, q);
    end
    model_step(2, 1'b0, 32'h402, 32'h0, eq, ef, ec);
    access(2, 1'b0, 32'h402, 32'h0, q, f, fc, ac, an, bn);
    tests++;
    if (f !== 1'b1 || fc !== 2'b11 || q !== 32'd0) begin
      fails++;
      $display("FAIL oor_misaligned: got f=%b fc=%b q=%h want 1 11 0", f, fc, q);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pat;
    int bad;
    pat = '0; bad = 0;
    req2 = 1'b1; wr2 = 1'b0; a2 = 32'h10; d2 = $urandom;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (ack2) begin
        pat[c-1] = 1'b1;
        if (q2 !== mdl2[4] || f2 !== 1'b0) bad++;
        a2 = 32'h10;
      end else if (busy2) begin
        a2 = $urandom;
      end
      if (c == 16) req2 = 1'b0;
    end
    last2 = mdl2[4];
    tests++;
    if (pat !== 16'h4444) begin
      fails++;
      $display("FAIL b2b_ack_pattern: got %b want %b", pat, 16'h4444);
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL b2b_data: got %0d bad responses want 0", bad);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic [31:0] q, eq;
    logic f, ef;
    logic [1:0] fc, ec;
    int ac, an, bn, acks;
    model_step(2, 1'b1, 32'h20, 32'h11111111, eq, ef, ec);
    access(2, 1'b1, 32'h20, 32'h11111111, q, f, fc, ac, an, bn);
    // Reset while counting down
    req2 = 1'b1; wr2 = 1'b1; a2 = 32'h20; d2 = 32'h22222222;
    @(negedge clk);
    tests++;
    if (busy2 !== 1'b1) begin
      fails++;
      $display("FAIL abort_busy: got %b want 1", busy2);
    end
    rst2 = 1'b1; req2 = 1'b0;
    @(negedge clk);
    tests++;
    if ({q2, ack2, busy2, f2, fc2} !== 37'd0) begin
      fails++;
      $display("FAIL abort_outputs: got q=%h ack=%b busy=%b f=%b fc=%b want 0",
               q2, ack2, busy2, f2, fc2);
    end
    rst2 = 1'b0;
    last2 = '0;
    // Reset on the edge that would enter the response state
    req2 = 1'b1; d2 = 32'h33333333;
    repeat (2) @(negedge clk);
    rst2 = 1'b1; req2 = 1'b0;
    @(negedge clk);
    rst2 = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack2) acks++;
    end
    tests++;
    if (acks !== 0) begin
      fails++;
      $display("FAIL abort_no_ack: got %0d acks want 0", acks);
    end
    model_step(2, 1'b0, 32'h20, 32'h0, eq, ef, ec);
    access(2, 1'b0, 32'h20, 32'h0, q, f, fc, ac, an, bn);
    tests++;
    if (q !== 32'h11111111) begin
      fails++;
      $display("FAIL abort_storage: got %h want 11111111", q);
    end
  endtask

  task automatic test_latency0();
    logic [31:0] q, eq;
    logic f, ef;
    logic [1:0] fc, ec;
    int ac, an, bn, bad;
    logic [7:0] pat;
    model_step(0, 1'b1, 32'h8, 32'hCAFEF00D, eq, ef, ec);
    access(0, 1'b1, 32'h8, 32'hCAFEF00D, q, f, fc, ac, an, bn);
    tests++;
    if (ac !== 1 || bn !== 1 || f !== 1'b0) begin
      fails++;
      $display("FAIL l0_wr: got cyc=%0d busy=%0d f=%b want 1 1 0", ac, bn, f);
    end
    model_step(0, 1'b0, 32'h8, 32'h0, eq, ef, ec);
    access(0, 1'b0, 32'h8, 32'h0, q, f, fc, ac, an, bn);
    tests++;
    if (ac !== 1 || q !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL l0_rd: got cyc=%0d q=%h want 1 cafef00d", ac, q);
    end
    pat = '0; bad = 0;
    req0 = 1'b1; wr0 = 1'b0; a0 = 32'h8;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ack0) begin
        pat[c-1] = 1'b1;
        if (q0 !== 32'hCAFEF00D) bad++;
      end
      if (c == 8) req0 = 1'b0;
    end
    tests++;
    if (pat !== 8'h55 || bad !== 0) begin
      fails++;
      $display("FAIL l0_b2b: got pattern %b bad=%0d want %b 0", pat, bad, 8'h55);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] q, eq, addr, dat;
    logic f, ef, w;
    logic [1:0] fc, ec;
    int ac, an, bn, lat, sel;
    for (int which = 0; which <= 2; which += 2) begin
      lat = which;
      for (int n = 0; n < 72; n++) begin
        if (n < 32) begin
          w = 1'b1; addr = n * 4;
        end else begin
          w = 1'($urandom_range(0, 1));
          addr = $urandom_range(0, 31) * 4;
          sel = $urandom_range(0, 7);
          if (sel == 0) addr[1:0] = 2'($urandom_range(1, 3));
          if (sel == 1) addr[31:2] = 30'($urandom_range(256, 32'h3FFFFFFF));
        end
        dat = $urandom;
        model_step(which, w, addr, dat, eq, ef, ec);
        access(which, w, addr, dat, q, f, fc, ac, an, bn);
        tests++;
        if (q !== eq || f !== ef || fc !== ec) begin
          fails++;
          $display("FAIL rand_l%0d_resp: a=%h w=%b got q=%h f=%b fc=%b want %h %b %b",
                   lat, addr, w, q, f, fc, eq, ef, ec);
        end
        tests++;
        if (ac !== lat + 1 || an !== 1 || bn !== lat + 1) begin
          fails++;
          $display("FAIL rand_l%0d_timing: got cyc=%0d n=%0d busy=%0d want %0d 1 %0d",
                   lat, ac, an, bn, lat + 1, lat + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_back_to_back();
    test_reset_abort();
    test_latency0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
